// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state encodings,
// and the bit positions of the {Z,C,N,V} flag register.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASSA = 4'd0,
        OP_PASSB = 4'd1,
        OP_NOTA  = 4'd2,
        OP_NOTB  = 4'd3,
        OP_ADD   = 4'd4,
        OP_ADDC  = 4'd5,
        OP_SUB   = 4'd6,
        OP_AND   = 4'd7,
        OP_OR    = 4'd8,
        OP_XOR   = 4'd9,
        OP_NAND  = 4'd10,
        OP_LSL1  = 4'd11,
        OP_LSR1  = 4'd12,
        OP_ASR1  = 4'd13,
        OP_SHLN  = 4'd14,
        OP_MUL   = 4'd15
    } alu_op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath for SHLN (one bit per step) and shift-add MUL (one
// multiplier bit per step). res_o/carry_o show the value after the current step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             mul_i,
    input  logic             half_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [CW-1:0]    n_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             done_o
);

    localparam int HW = WIDTH / 2;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0]   mlt_q, mlt_d;
    logic [WIDTH-1:0]   mask;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mul_q, half_q;

    assign mask = half_q ? WIDTH'({HW{1'b1}}) : {WIDTH{1'b1}};

    always_comb begin
        acc_d = (mul_q && mlt_q[0]) ? acc_q + mc_q : acc_q;
        mc_d  = mc_q << 1;
        mlt_d = mlt_q >> 1;
        cnt_d = cnt_q - CW'(1);
    end

    // cnt_q holds steps remaining minus one, so the terminal step is cnt_q == 0.
    assign done_o = step_i && (cnt_q == '0);
    assign res_o  = mul_q ? (acc_d[WIDTH-1:0] & mask) : (mc_d[WIDTH-1:0] & mask);

    always_comb begin
        if (mul_q) begin
            carry_o = half_q ? |acc_d[WIDTH-1:HW] : |acc_d[2*WIDTH-1:WIDTH];
        end else begin
            carry_o = half_q ? mc_q[HW-1] : mc_q[WIDTH-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            mc_q   <= '0;
            mlt_q  <= '0;
            cnt_q  <= '0;
            mul_q  <= 1'b0;
            half_q <= 1'b0;
        end else if (start_i) begin
            acc_q  <= '0;
            mc_q   <= {{WIDTH{1'b0}}, a_i};
            mlt_q  <= b_i;
            cnt_q  <= n_i - CW'(1);
            mul_q  <= mul_i;
            half_q <= half_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
            mlt_q <= mlt_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready accept, IDLE/BUSY/DONE sequencing, single-cycle
// datapath, flag generation and the registered result/flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [4:0]       FunSel,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       flags,
    output logic             out_valid,
    output logic [1:0]       dbg_state_o
);

    // Handshake: an op is taken on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE outside reset, so a held request waits.
    localparam int HW    = WIDTH / 2;
    localparam int CW    = $clog2(WIDTH) + 1;
    localparam int AMT_H = $clog2(HW);
    localparam int AMT_F = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [3:0]       flags_q, flags_d;
    logic             half_q, half_d;

    logic             half, accept, is_iter, it_start, it_done, it_carry;
    alu_op_e          op;
    logic [WIDTH-1:0] mask, top_m, a_m, b_m, bx, sc_res, it_res;
    logic [WIDTH:0]   sum;
    logic [CW-1:0]    amt, iter_n;
    logic             cin_bit, add_c, add_v, sc_c, sc_v;

    function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic h);
        return h ? v[HW-1] : v[WIDTH-1];
    endfunction

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                            input logic v, input logic h);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_N] = msb_of(r, h);
        f[FLAG_V] = v;
        return f;
    endfunction

    assign half     = ~FunSel[4];
    assign op       = alu_op_e'(FunSel[3:0]);
    assign mask     = half ? WIDTH'({HW{1'b1}}) : {WIDTH{1'b1}};
    assign top_m    = mask ^ (mask >> 1);
    assign a_m      = input_a & mask;
    assign b_m      = input_b & mask;
    assign in_ready = (state_q == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    assign amt     = half ? CW'(input_b[AMT_H-1:0]) : CW'(input_b[AMT_F-1:0]);
    assign is_iter = (op == OP_MUL) || ((op == OP_SHLN) && (amt != '0));
    assign iter_n  = (op == OP_MUL) ? (half ? CW'(HW) : CW'(WIDTH)) : amt;

    // SUB is A + ~B + 1 over the active width; the same adder serves ADD/ADDC.
    always_comb begin
        bx      = (op == OP_SUB) ? (~input_b & mask) : b_m;
        cin_bit = (op == OP_SUB) || ((op == OP_ADDC) && flags_q[FLAG_C]);
        sum     = {1'b0, a_m} + {1'b0, bx} + {{WIDTH{1'b0}}, cin_bit};
        add_c   = half ? sum[HW] : sum[WIDTH];
        add_v   = (msb_of(a_m, half) == msb_of(bx, half)) &&
                  (msb_of(sum[WIDTH-1:0], half) != msb_of(a_m, half));
    end

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            OP_PASSA: sc_res = a_m;
            OP_PASSB: sc_res = b_m;
            OP_NOTA:  sc_res = ~input_a & mask;
            OP_NOTB:  sc_res = ~input_b & mask;
            OP_ADD, OP_ADDC, OP_SUB: begin
                sc_res = sum[WIDTH-1:0] & mask;
                sc_c   = add_c;
                sc_v   = add_v;
            end
            OP_AND:   sc_res = a_m & b_m;
            OP_OR:    sc_res = a_m | b_m;
            OP_XOR:   sc_res = a_m ^ b_m;
            OP_NAND:  sc_res = ~(a_m & b_m) & mask;
            OP_LSL1: begin
                sc_res = (a_m << 1) & mask;
                sc_c   = msb_of(a_m, half);
            end
            OP_LSR1: begin
                sc_res = a_m >> 1;
                sc_c   = a_m[0];
            end
            OP_ASR1: begin
                sc_res = (a_m >> 1) | (msb_of(a_m, half) ? top_m : '0);
                sc_c   = a_m[0];
            end
            // Only SHLN with a zero amount completes here: result is A, C=0.
            default:  sc_res = a_m;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        aluout_d = aluout_q;
        flags_d  = flags_q;
        half_d   = half_q;
        it_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    half_d = half;
                    if (is_iter) begin
                        it_start = 1'b1;
                        state_d  = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        aluout_d = sc_res;
                        flags_d  = mk_flags(sc_res, sc_c, sc_v, half);
                    end
                end
            end
            ST_BUSY: begin
                if (it_done) begin
                    state_d  = ST_DONE;
                    aluout_d = it_res;
                    flags_d  = mk_flags(it_res, it_carry, 1'b0, half_q);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            aluout_q <= '0;
            flags_q  <= '0;
            half_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            aluout_q <= aluout_d;
            flags_q  <= flags_d;
            half_q   <= half_d;
        end
    end

    alu_iter_unit #(
        .WIDTH(WIDTH),
        .CW   (CW)
    ) u_iter (
        .clk_i  (clock),
        .rst_i  (reset),
        .start_i(it_start),
        .step_i (state_q == ST_BUSY),
        .mul_i  (op == OP_MUL),
        .half_i (half),
        .a_i    (a_m),
        .b_i    (b_m),
        .n_i    (iter_n),
        .res_o  (it_res),
        .carry_o(it_carry),
        .done_o (it_done)
    );

    assign ALUOut      = aluout_q;
    assign flags       = flags_q;
    assign out_valid   = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, hand-written multi-cycle and reset
// sequences, then random ops checked against an arithmetic reference model.
module tb_alu_mc;

    localparam int LAT_MAX = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_a, input_b;
    logic [4:0]  FunSel;
    logic [31:0] ALUOut;
    logic [3:0]  flags;
    logic        out_valid;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  cur_flags;

    typedef struct {
        logic [4:0]  fs;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        string       name;
    } vec_t;

    vec_t tbl[$];

    alu_mc #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input_a    (input_a),
        .input_b    (input_b),
        .FunSel     (FunSel),
        .ALUOut     (ALUOut),
        .flags      (flags),
        .out_valid  (out_valid),
        .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic longint to_s(input longint unsigned x, input int aw);
        if (x[aw-1]) return longint'(x) - (longint'(1) <<< aw);
        return longint'(x);
    endfunction

    // Reference: plain integer arithmetic over the active width.
    function automatic void model(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] res,
                                  output logic [3:0] fl, output int lat);
        int aw, amt;
        longint unsigned m, ua, ub, r, p;
        longint sr, lo, hi;
        logic c, v;
        aw  = fs[4] ? 32 : 16;
        m   = (64'd1 << aw) - 64'd1;
        ua  = {32'd0, a} & m;
        ub  = {32'd0, b} & m;
        hi  = (longint'(1) <<< (aw - 1)) - 1;
        lo  = -(longint'(1) <<< (aw - 1));
        r   = 0; p = 0; sr = 0; c = 1'b0; v = 1'b0; lat = 1;
        case (fs[3:0])
            4'd0:  r = ua;
            4'd1:  r = ub;
            4'd2:  r = ~ua & m;
            4'd3:  r = ~ub & m;
            4'd4, 4'd5: begin
                p  = ua + ub + ((fs[3:0] == 4'd5 && cin) ? 64'd1 : 64'd0);
                r  = p & m;
                c  = p[aw];
                sr = to_s(ua, aw) + to_s(ub, aw) + ((fs[3:0] == 4'd5 && cin) ? 1 : 0);
                v  = (sr > hi) || (sr < lo);
            end
            4'd6: begin
                r  = (ua - ub) & m;
                c  = (ua >= ub);
                sr = to_s(ua, aw) - to_s(ub, aw);
                v  = (sr > hi) || (sr < lo);
            end
            4'd7:  r = ua & ub;
            4'd8:  r = ua | ub;
            4'd9:  r = ua ^ ub;
            4'd10: r = ~(ua & ub) & m;
            4'd11: begin r = (ua << 1) & m; c = ua[aw-1]; end
            4'd12: begin r = ua >> 1; c = ua[0]; end
            4'd13: begin r = (ua >> 1) | (ua & (64'd1 << (aw - 1))); c = ua[0]; end
            4'd14: begin
                amt = fs[4] ? int'(b[4:0]) : int'(b[3:0]);
                r   = (ua << amt) & m;
                c   = (amt == 0) ? 1'b0 : ua[aw-amt];
                lat = 1 + amt;
            end
            default: begin
                p   = ua * ub;
                r   = p & m;
                c   = (p >> aw) != 0;
                lat = 1 + aw;
            end
        endcase
        res = r[31:0];
        fl  = {r == 0, c, r[aw-1], v};
    endfunction

    // Issue one op from a negedge in IDLE and follow it to its completion pulse.
    // For hold > 0, a competing request is held while busy and must be ignored.
    task automatic run_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [3:0] ef, input int el,
                          input int hold, input string tag);
        int   lat;
        logic ready_low;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        FunSel = fs; input_a = a; input_b = b; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        FunSel   = 5'($urandom);
        input_a  = $urandom;
        input_b  = $urandom;
        lat       = 0;
        ready_low = 1'b1;
        while (lat < LAT_MAX) begin
            @(negedge clock);
            lat++;
            if (out_valid) break;
            if (in_ready) ready_low = 1'b0;
            if (lat <= hold) begin
                in_valid = 1'b1;
                FunSel   = 5'h14;
                input_a  = $urandom;
                input_b  = $urandom;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " ALUOut"}, 64'(ALUOut), 64'(er));
        check({tag, " flags"}, 64'(flags), 64'(ef));
        if (el > 1) check({tag, " in_ready low while busy"}, 64'(ready_low), 64'd1);
        @(negedge clock);
        check({tag, " out_valid pulse"}, 64'(out_valid), 64'd0);
        cur_flags = ef;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_8000;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] er;
        logic [3:0]  ef;
        int          el;
        logic        ov_seen;
        logic [4:0]  fs;
        logic [31:0] ra, rb;

        reset = 1'b1; in_valid = 1'b0; FunSel = '0; input_a = '0; input_b = '0;
        cur_flags = '0;
        repeat (3) @(negedge clock);
        check("reset ALUOut", 64'(ALUOut), 64'd0);
        check("reset flags", 64'(flags), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);
        @(negedge clock);

        tbl.push_back('{5'h14, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1100, 1,  "add_full_wrap"});
        tbl.push_back('{5'h15, 32'h0,         32'h0,         32'h1,         4'b0000, 1,  "addc_after_carry"});
        tbl.push_back('{5'h06, 32'h0000_8000, 32'h1,         32'h0000_7FFF, 4'b0101, 1,  "sub_half_ovf"});
        tbl.push_back('{5'h1F, 32'h0001_0000, 32'h0001_0000, 32'h0,         4'b1100, 33, "mul_full_discard"});
        tbl.push_back('{5'h0E, 32'h0000_9001, 32'h4,         32'h0000_0010, 4'b0100, 5,  "shln_half_4"});
        tbl.push_back('{5'h0E, 32'h0000_9001, 32'h0,         32'h0000_9001, 4'b0010, 1,  "shln_half_0"});
        tbl.push_back('{5'h17, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0010, 1,  "and_full"});
        tbl.push_back('{5'h0C, 32'h0000_0003, 32'h0,         32'h0000_0001, 4'b0100, 1,  "lsr1_half"});
        tbl.push_back('{5'h0D, 32'h0000_8001, 32'h0,         32'h0000_C000, 4'b0110, 1,  "asr1_half"});
        tbl.push_back('{5'h0A, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0,         4'b1000, 1,  "nand_half"});
        tbl.push_back('{5'h04, 32'hABCD_7FFF, 32'h1234_0001, 32'h0000_8000, 4'b0011, 1,  "add_half_ovf"});
        tbl.push_back('{5'h13, 32'h0,         32'h0,         32'hFFFF_FFFF, 4'b0010, 1,  "notb_full"});
        tbl.push_back('{5'h01, 32'h0,         32'hFFFF_1234, 32'h0000_1234, 4'b0000, 1,  "passb_half_zext"});
        tbl.push_back('{5'h0F, 32'h0000_0100, 32'h0000_0100, 32'h0,         4'b1100, 17, "mul_half_discard"});
        tbl.push_back('{5'h1B, 32'h8000_0001, 32'h0,         32'h0000_0002, 4'b0100, 1,  "lsl1_full"});

        foreach (tbl[i]) begin
            run_op(tbl[i].fs, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].fl, tbl[i].lat, 0, tbl[i].name);
        end

        // Request held while a MUL is busy must not disturb it.
        run_op(5'h1F, 32'd7, 32'd9, 32'd63, 4'b0000, 33, 20, "mul_ignore_req");

        // Reset in the middle of a MUL aborts it.
        FunSel = 5'h1F; input_a = 32'd3; input_b = 32'd5; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        ov_seen  = 1'b0;
        repeat (9) begin
            @(negedge clock);
            ov_seen |= out_valid;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            ov_seen |= out_valid;
        end
        check("mid_mul reset ALUOut", 64'(ALUOut), 64'd0);
        check("mid_mul reset flags", 64'(flags), 64'd0);
        check("mid_mul reset in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("mid_mul in_ready after release", 64'(in_ready), 64'd1);
        cur_flags = '0;
        run_op(5'h14, 32'd2, 32'd3, 32'd5, 4'b0000, 1, 0, "add_after_reset");
        repeat (40) begin
            @(negedge clock);
            ov_seen |= out_valid;
        end
        check("mid_mul no completion", 64'(ov_seen), 64'd0);

        for (int i = 0; i < 60; i++) begin
            fs = 5'($urandom_range(0, 31));
            ra = pick_operand();
            rb = pick_operand();
            model(fs, ra, rb, cur_flags[2], er, ef, el);
            run_op(fs, ra, rb, er, ef, el, 0, $sformatf("rand%0d op%0h", i, fs));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor of the datapath ALU. Adds a generic data width, a valid/ready input handshake, a completion pulse, and two iterative operations: shift-left-by-amount and shift-add multiply. Flags are state held in the block, and carry-in for ADDC is taken from that state. Sits between the register file read ports and the writeback mux; the control unit stalls on `in_ready`.

## Interface
- `WIDTH`, 32, full operand width; even, ≥ 8.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; `in_ready = (state==IDLE) && !reset`.
- `input_a`  in  WIDTH  operand A.
- `input_b`  in  WIDTH  operand B; for SHLN, also the shift amount.
- `FunSel`  in  5  operation select:
  - `[4]` is size: 0 selects half (HW=WIDTH/2), 1 selects full (FW=WIDTH).
  - `[3:0]` is the opcode.
- `ALUOut`  out  WIDTH  registered result; half mode is zero-extended; held until the next completion.
- `flags`  out  4  registered {Z,C,N,V}.
- `out_valid`  out  1  one-cycle completion pulse.

## Operation
- An op is accepted on a rising edge with `in_valid && in_ready`. Operands, `FunSel` and current `flags[C]` are captured at that edge.
- Active width is AW = HW or FW. Only the low AW bits of the operands are used.
- Opcodes:
  - 0 PASSA, 1 PASSB, 2 NOTA, 3 NOTB.
  - 4 ADD, 5 ADDC (A+B+Cin), 6 SUB (A + ~B + 1).
  - 7 AND, 8 OR, 9 XOR, 10 NAND.
  - 11 LSL1, 12 LSR1, 13 ASR1.
  - 14 SHLN: shift left by `input_b[log2(AW)-1:0]`.
  - 15 MUL: low AW bits of A×B, unsigned.
- Opcodes 0–13 are single-cycle. SHLN iterates one bit per cycle, `amt` cycles. MUL iterates one multiplier bit per cycle, AW cycles.
- FSM states: IDLE, BUSY, DONE.
  - IDLE goes to DONE on accept of a single-cycle op, or of SHLN with amt=0.
  - IDLE goes to BUSY otherwise.
  - BUSY goes to DONE when the iteration counter reaches its terminal count.
  - DONE goes to IDLE unconditionally. In that cycle `out_valid=1` and `ALUOut`/`flags` are already updated.
- `flags` and `ALUOut` change only on the edge that enters DONE.
- Flag rules, evaluated over AW bits:
  - Z: result == 0.
  - N: result[AW-1].
  - C for ADD/ADDC: carry out of bit AW-1.
  - C for SUB: 1 when A ≥ B (no borrow).
  - C for LSL1 and SHLN: last bit shifted out. SHLN with amt=0 gives C=0.
  - C for LSR1/ASR1: A[0].
  - C for MUL: 1 when any discarded product bit is nonzero.
  - C for all other ops: 0.
  - V for ADD/ADDC: signed overflow.
  - V for SUB: signed overflow computed with inverted B.
  - V for all other ops: 0.
- No output backpressure. The consumer must sample in the `out_valid` cycle or later.

## Timing
- Latency is L cycles from the accepting edge to the `out_valid` cycle:
  - single-cycle ops: L=1.
  - SHLN: L = 1 + amt.
  - MUL: L = 1 + AW.
- `in_ready` is low in BUSY and DONE. Back-to-back single-cycle ops therefore issue every 2 cycles.
- Reset while `reset` is high:
  - state is IDLE; `ALUOut`=0, `flags`=0, `out_valid`=0, `in_ready`=0.
  - Reset mid-BUSY aborts the op; no `out_valid` is produced.
  - `in_ready`=1 in the first cycle after `reset` falls.
- `in_valid` with `in_ready`=0 is ignored. The requester holds the request.
- ADDC immediately after a completion sees the flags written by that completion.

## Structure
- Package `alu_pkg` holds:
  - opcode enum `alu_op_e` (4 bits);
  - flag index constants `FLAG_Z=3`, `FLAG_C=2`, `FLAG_N=1`, `FLAG_V=0`;
  - FSM state enum `alu_state_e`.
- Sub-module `alu_iter_unit` holds the SHLN/MUL iterative datapath: accumulator, shift register, counter, `done` output. Top level holds the FSM, the single-cycle datapath, flag logic and output registers.

## Test plan
- ADD full, A=FFFFFFFF, B=1 → ALUOut=0, flags Z1 C1 N0 V0; `out_valid` 1 cycle after accept.
- SUB half, A=00008000, B=1 → ALUOut=00007FFF, flags Z0 C1 N0 V1.
- MUL full, A=B=00010000 → ALUOut=0, Z1 C1; `out_valid` exactly 33 cycles after accept; `in_ready` low throughout.
- ADD FFFFFFFF+1, then ADDC 0+0 → second result 00000001, C=0.
- SHLN half, A=9001, B=4 → 0010, C=1, L=5. Then B=0 → 9001, C=0, L=1.
- Assert `reset` at cycle 10 of a MUL → no `out_valid`, ALUOut=0, flags=0; a new ADD is accepted the cycle after release.
